// File: rtl/delay_sweep_ctrl.sv
// Wishbone-slave delay-line sweep sequencer: steps the delay code, samples the comparator, reports the first flip.
// Optional SWEEP_IRQ_EN adds irq_o (set on sweep completion) and CTRL read bit 3.
module delay_sweep_ctrl #(
  parameter int unsigned CODE_W        = 10,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned STB_CYCLES    = 4,
  parameter int unsigned SMP_DELAY     = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_stall_o,
  output logic              wb_err_o,
  output logic [CODE_W-1:0] delay_code_o,
  output logic              delay_stb_o,
  input  logic              cmp_i
`ifdef SWEEP_IRQ_EN
  ,
  output logic              irq_o
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_STROBE,
    ST_WAIT,
    ST_SAMPLE,
    ST_EVAL,
    ST_DONE
  } state_t;

  localparam int unsigned     CNT_W       = 16;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST    = CNT_W'(STB_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(SMP_DELAY - 1);

  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_START   = 3'd1;
  localparam logic [2:0] A_STOP    = 3'd2;
  localparam logic [2:0] A_STEP    = 3'd3;
  localparam logic [2:0] A_SAMPLES = 3'd4;
  localparam logic [2:0] A_RESULT  = 3'd5;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          ones_q, ones_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   start_q, start_d;
  logic [CODE_W-1:0]   stop_q, stop_d;
  logic [CODE_W-1:0]   step_q, step_d;
  logic [7:0]          samples_q, samples_d;
  logic [CODE_W-1:0]   res_code_q, res_code_d;
  logic                res_lvl_q, res_lvl_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                found_q, found_d;
  logic                ref_q, ref_d;
  logic                first_q, first_d;
  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic                meta_q, sync_q;

  logic                wb_req, wb_wr, ctrl_wr, cfg_wr;
  logic                start_req, abort_req, start_go;
  logic [2:0]          reg_sel;
  logic [31:0]         rdata;
  logic [CODE_W:0]     next_code;
  logic                level;
  logic                irq_bit;
  logic                unused_ok;

  assign wb_req    = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wb_wr     = wb_req & wb_we_i;
  assign reg_sel   = wb_adr_i[4:2];
  assign ctrl_wr   = wb_wr && (reg_sel == A_CTRL);
  assign cfg_wr    = wb_wr & ~busy_q;
  assign start_req = ctrl_wr & wb_dat_i[0];
  assign abort_req = ctrl_wr & wb_dat_i[1];
  assign start_go  = (state_q == ST_IDLE) & start_req & ~abort_req;

  // Extra bit catches wrap past the top code so the sweep never restarts at 0.
  assign next_code = {1'b0, code_q} + {1'b0, step_q};
  assign level     = ({ones_q, 1'b0} > {1'b0, samples_q});

  assign wb_stall_o   = 1'b0;
  assign wb_err_o     = 1'b0;
  assign wb_ack_o     = ack_q;
  assign wb_dat_o     = dat_q;
  assign delay_code_o = code_q;
  assign delay_stb_o  = (state_q == ST_STROBE);

  assign unused_ok = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i[31:8]};

  // Configuration registers; frozen while a sweep is running.
  always_comb begin
    start_d   = start_q;
    stop_d    = stop_q;
    step_d    = step_q;
    samples_d = samples_q;
    if (cfg_wr) begin
      unique case (reg_sel)
        A_START: start_d = wb_dat_i[CODE_W-1:0];
        A_STOP:  stop_d  = wb_dat_i[CODE_W-1:0];
        A_STEP:  step_d  = (wb_dat_i[CODE_W-1:0] == '0) ? CODE_W'(1) : wb_dat_i[CODE_W-1:0];
        A_SAMPLES: samples_d = (wb_dat_i[7:0] == '0) ? 8'd1 : wb_dat_i[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      A_CTRL:    rdata = {28'd0, irq_bit, found_q, done_q, busy_q};
      A_START:   rdata = 32'(start_q);
      A_STOP:    rdata = 32'(stop_q);
      A_STEP:    rdata = 32'(step_q);
      A_SAMPLES: rdata = {24'd0, samples_q};
      A_RESULT: begin
        rdata[CODE_W-1:0] = res_code_q;
        rdata[31]         = res_lvl_q;
      end
      default:   rdata = '0;
    endcase
  end

  always_comb begin
    ack_d = wb_req;
    dat_d = (wb_req && !wb_we_i) ? rdata : '0;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ones_d     = ones_q;
    code_d     = code_q;
    busy_d     = busy_q;
    done_d     = done_q;
    found_d    = found_q;
    ref_d      = ref_q;
    first_d    = first_q;
    res_code_d = res_code_q;
    res_lvl_d  = res_lvl_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_go) begin
          code_d  = start_q;
          done_d  = 1'b0;
          found_d = 1'b0;
          busy_d  = 1'b1;
          first_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == STB_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          ones_d  = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        ones_d = ones_q + {7'd0, sync_q};
        if (cnt_q[7:0] == samples_q - 8'd1) begin
          cnt_d   = '0;
          state_d = ST_EVAL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EVAL: begin
        if (!first_q && (level != ref_q)) begin
          res_code_d = code_q;
          res_lvl_d  = level;
          found_d    = 1'b1;
          state_d    = ST_DONE;
        end else begin
          if (first_q) begin
            ref_d   = level;
            first_d = 1'b0;
          end
          if (next_code[CODE_W] || (next_code[CODE_W-1:0] > stop_q)) begin
            state_d = ST_DONE;
          end else begin
            code_d  = next_code[CODE_W-1:0];
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides whatever the sweep would have done this cycle, including a RESULT update.
    if (abort_req && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      cnt_d      = '0;
      res_code_d = res_code_q;
      res_lvl_d  = res_lvl_q;
      found_d    = found_q;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ones_q     <= '0;
      code_q     <= '0;
      start_q    <= '0;
      stop_q     <= '0;
      step_q     <= CODE_W'(1);
      samples_q  <= 8'd1;
      res_code_q <= '0;
      res_lvl_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      ref_q      <= 1'b0;
      first_q    <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ones_q     <= ones_d;
      code_q     <= code_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      step_q     <= step_d;
      samples_q  <= samples_d;
      res_code_q <= res_code_d;
      res_lvl_q  <= res_lvl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      found_q    <= found_d;
      ref_q      <= ref_d;
      first_q    <= first_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      meta_q     <= cmp_i;
      sync_q     <= meta_q;
    end
  end

`ifdef SWEEP_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if ((ctrl_wr && wb_dat_i[2]) || start_go) begin
      irq_d = 1'b0;
    end
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      irq_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o   = irq_q;
  assign irq_bit = irq_q;
`else
  assign irq_bit = 1'b0;
`endif

endmodule

// File: tb/tb_delay_sweep_ctrl.sv
// Directed self-checking bench for delay_sweep_ctrl (default build, no irq port).
module tb_delay_sweep_ctrl;

  logic        clk;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_i;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic        ack, stall, err;
  logic [9:0]  code;
  logic        dstb;
  logic        cmp_i;

  logic        use_thr;
  logic [9:0]  thr;
  logic        cmp_man;

  int          tests = 0;
  int          fails = 0;

  logic        stb_prev = 1'b0;
  int          stb_cnt  = 0;
  int          zero_cnt = 0;
  logic [9:0]  stb_log [64];
  logic        stb_at_ack;

  assign cmp_i = use_thr ? (code >= thr) : cmp_man;

  delay_sweep_ctrl #(
    .CODE_W        (10),
    .SETTLE_CYCLES (16),
    .STB_CYCLES    (4),
    .SMP_DELAY     (2)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wb_cyc_i     (cyc),
    .wb_stb_i     (stb),
    .wb_we_i      (we),
    .wb_adr_i     (adr),
    .wb_dat_i     (dat_i),
    .wb_sel_i     (sel),
    .wb_dat_o     (dat_o),
    .wb_ack_o     (ack),
    .wb_stall_o   (stall),
    .wb_err_o     (err),
    .delay_code_o (code),
    .delay_stb_o  (dstb),
    .cmp_i        (cmp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe/code monitor: logs the code presented at every strobe rising edge.
  always @(posedge clk) begin
    stb_prev <= dstb;
    if (dstb && !stb_prev) begin
      stb_log[stb_cnt % 64] <= code;
      stb_cnt <= stb_cnt + 1;
    end
    if (code == 10'd0) zero_cnt <= zero_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic w, input logic [2:0] a, input logic [31:0] d,
                         output logic [31:0] q);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = {27'd0, a, 2'b00}; dat_i = d;
    @(posedge clk); #1;
    check("ack_one_cycle", {31'd0, ack}, 32'd1);
    q = dat_o;
    stb_at_ack = dstb;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("ack_drops", {31'd0, ack}, 32'd0);
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, a, d, q);
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] q);
    wb_xfer(1'b0, a, 32'd0, q);
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] q;
    wb_read(a, q);
    check(tag, q, exp);
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] r;
    bit got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      wb_read(3'd0, r);
      if (r[1]) got = 1'b1;
    end
    check(tag, {31'd0, got}, 32'd1);
  endtask

  task automatic wait_stb(input logic lvl, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(posedge clk); #1;
      if (dstb === lvl) ok = 1'b1;
    end
  endtask

  // Drives a 4-sample comparator pattern (msb first) aligned to the next strobe's sample window.
  task automatic drive_point(input string tag, input logic [3:0] pat);
    bit ok_hi, ok_lo;
    wait_stb(1'b1, 200, ok_hi);
    wait_stb(1'b0, 20, ok_lo);
    check(tag, {30'd0, ok_hi, ok_lo}, 32'd3);
    for (int k = 3; k >= 0; k--) begin
      cmp_man = pat[k];
      @(posedge clk); #1;
    end
    cmp_man = 1'b0;
  endtask

  initial begin
    int          base_stb;
    int          base_zero;
    bit          ok;
    logic [31:0] exp_reset [8];

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; sel = 4'hF;
    use_thr = 1'b0; thr = '0; cmp_man = 1'b0; stb_at_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_code", {22'd0, code}, 32'd0);
    check("rst_dstb", {31'd0, dstb}, 32'd0);
    check("tie_stall_err", {30'd0, stall, err}, 32'd0);
    rst = 1'b0;

    exp_reset = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0};
    for (int a = 0; a < 8; a++) read_check("reset_reg", 3'(a), exp_reset[a]);

    wb_write(3'd3, 32'd0);
    read_check("step_zero_is_one", 3'd3, 32'd1);
    wb_write(3'd4, 32'd0);
    read_check("samples_zero_is_one", 3'd4, 32'd1);
    wb_write(3'd6, 32'hFFFF_FFFF);
    read_check("addr6_reads_zero", 3'd6, 32'd0);

    // Edge at 25 with threshold comparator.
    wb_write(3'd1, 32'd10);
    wb_write(3'd2, 32'd40);
    wb_write(3'd3, 32'd5);
    wb_write(3'd4, 32'd3);
    use_thr = 1'b1; thr = 10'd25;
    base_stb = stb_cnt;
    wb_write(3'd0, 32'd1);
    wait_done("edge_done");
    read_check("edge_ctrl", 3'd0, 32'd6);
    read_check("edge_result", 3'd5, 32'h8000_0019);
    check("edge_strobes", 32'(stb_cnt - base_stb), 32'd4);

    // No edge: full range swept, busy-time config writes ignored.
    use_thr = 1'b0; cmp_man = 1'b0;
    base_stb = stb_cnt;
    wb_write(3'd0, 32'd1);
    wb_write(3'd2, 32'd20);
    read_check("busy_write_ignored", 3'd2, 32'd40);
    wait_done("flat_done");
    read_check("flat_ctrl", 3'd0, 32'd2);
    read_check("flat_result_kept", 3'd5, 32'h8000_0019);
    check("flat_strobes", 32'(stb_cnt - base_stb), 32'd7);
    for (int i = 0; i < 7; i++)
      check("flat_code_seq", {22'd0, stb_log[(base_stb + i) % 64]}, 32'(10 + 5 * i));
    check("flat_code_hold", {22'd0, code}, 32'd40);

    // Top-of-range: next code overflows, sweep must stop without wrapping.
    wb_write(3'd1, 32'h3FE);
    wb_write(3'd2, 32'h3FF);
    wb_write(3'd3, 32'd4);
    base_stb = stb_cnt;
    base_zero = zero_cnt;
    wb_write(3'd0, 32'd1);
    wait_done("ovf_done");
    read_check("ovf_ctrl", 3'd0, 32'd2);
    check("ovf_strobes", 32'(stb_cnt - base_stb), 32'd1);
    check("ovf_code_strobed", {22'd0, stb_log[base_stb % 64]}, 32'h3FE);
    check("ovf_code_hold", {22'd0, code}, 32'h3FE);
    check("ovf_no_wrap", 32'(zero_cnt - base_zero), 32'd0);

    // Majority tie (2 of 4) resolves to 0.
    wb_write(3'd1, 32'd0);
    wb_write(3'd2, 32'd1);
    wb_write(3'd3, 32'd1);
    wb_write(3'd4, 32'd4);
    wb_write(3'd0, 32'd1);
    drive_point("tie_point0", 4'b1111);
    drive_point("tie_point1", 4'b1100);
    wait_done("tie_done");
    read_check("tie_ctrl", 3'd0, 32'd6);
    read_check("tie_result", 3'd5, 32'h0000_0001);

    // Abort during strobe.
    wb_write(3'd1, 32'd0);
    wb_write(3'd2, 32'd5);
    wb_write(3'd4, 32'd1);
    wb_write(3'd0, 32'd1);
    wait_stb(1'b1, 200, ok);
    check("abort_saw_strobe", {31'd0, ok}, 32'd1);
    wb_write(3'd0, 32'd2);
    check("abort_stb_low", {31'd0, stb_at_ack}, 32'd0);
    read_check("abort_ctrl", 3'd0, 32'd0);
    read_check("abort_result_kept", 3'd5, 32'h0000_0001);
    wb_write(3'd0, 32'd3);
    read_check("start_abort_same", 3'd0, 32'd0);

    // Normal sweep after abort.
    use_thr = 1'b1; thr = 10'd3;
    wb_write(3'd0, 32'd1);
    wait_done("post_abort_done");
    read_check("post_abort_ctrl", 3'd0, 32'd6);
    read_check("post_abort_result", 3'd5, 32'h8000_0003);

    // Reset mid-sweep.
    use_thr = 1'b0;
    wb_write(3'd1, 32'd7);
    wb_write(3'd2, 32'd20);
    wb_write(3'd0, 32'd1);
    wait_stb(1'b1, 200, ok);
    check("rst_mid_saw_strobe", {31'd0, ok}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_code", {22'd0, code}, 32'd0);
    check("rst_mid_dstb", {31'd0, dstb}, 32'd0);
    rst = 1'b0;
    read_check("rst_mid_ctrl", 3'd0, 32'd0);
    read_check("rst_mid_start", 3'd1, 32'd0);
    read_check("rst_mid_step", 3'd3, 32'd1);
    read_check("rst_mid_result", 3'd5, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
